rob_commit: RTL and testbench

// - In-order reorder buffer and retirement unit; producer of the commit-side interface of the physical register/valid-bit state.
// - Allocates one entry per dispatched instruction and marks entries done from per-FU completion reports.
// - Retires at most one entry per cycle from the head, driving register free/set, flag writes and mispredict rollback.

---
 rtl/rob_commit_if.sv | 60 ++++++
 rtl/rob_commit.sv | 206 ++++++++++++++++++++
 tb/tb_rob_commit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_if.sv
// rob_commit_if: groups the dispatch, completion and commit-side signals of the
// reorder buffer into one bundle.
//   slave  modport : used by rob_commit. Dispatch and completion signals are
//                    inputs; the commit strobes, status and perf counters are outputs.
//   master modport : used by the environment, which drives dispatch and completion.
// Signal names keep their _i/_o suffixes as seen from the ROB.
interface rob_commit_if #(
    parameter int unsigned NUM_ROB      = 16,
    parameter int unsigned NUM_FU       = 4,
    parameter int unsigned NUM_PHYS_REG = 128,
    parameter int unsigned NUM_FLAGS    = 4
);
    localparam int unsigned IDX_W = $clog2(NUM_ROB);
    localparam int unsigned PR_W  = $clog2(NUM_PHYS_REG);

    // Dispatch
    logic                        dispatch_valid_i;
    logic                        dispatch_ready_o;
    logic                        dispatch_has_dest_i;
    logic [PR_W-1:0]             dispatch_phys_new_i;
    logic [PR_W-1:0]             dispatch_phys_old_i;
    logic [NUM_FLAGS-1:0]        dispatch_flag_mask_i;
    logic [IDX_W-1:0]            dispatch_idx_o;
    // Completion
    logic [NUM_FU-1:0]           complete_valid_i;
    logic [NUM_FU*IDX_W-1:0]     complete_idx_i;
    logic [NUM_FU*NUM_FLAGS-1:0] complete_flags_i;
    logic [NUM_FU-1:0]           complete_mispredict_i;
    // Commit side
    logic                        rob_phys_valid_o;
    logic [PR_W-1:0]             rob_phys_reg_cl_o;
    logic [PR_W-1:0]             rob_phys_reg_set_o;
    logic                        rob_phys_mispredict_o;
    logic                        rob_flag_valid_o;
    logic [2*NUM_FLAGS-1:0]      rob_flag_o;
    logic                        rob_empty_o;
    // Performance counters
    logic [31:0]                 perf_commit_cnt_o;
    logic [31:0]                 perf_stall_cnt_o;

    modport slave (
        input  dispatch_valid_i, dispatch_has_dest_i, dispatch_phys_new_i,
               dispatch_phys_old_i, dispatch_flag_mask_i,
               complete_valid_i, complete_idx_i, complete_flags_i, complete_mispredict_i,
        output dispatch_ready_o, dispatch_idx_o,
               rob_phys_valid_o, rob_phys_reg_cl_o, rob_phys_reg_set_o,
               rob_phys_mispredict_o, rob_flag_valid_o, rob_flag_o, rob_empty_o,
               perf_commit_cnt_o, perf_stall_cnt_o
    );

    modport master (
        output dispatch_valid_i, dispatch_has_dest_i, dispatch_phys_new_i,
               dispatch_phys_old_i, dispatch_flag_mask_i,
               complete_valid_i, complete_idx_i, complete_flags_i, complete_mispredict_i,
        input  dispatch_ready_o, dispatch_idx_o,
               rob_phys_valid_o, rob_phys_reg_cl_o, rob_phys_reg_set_o,
               rob_phys_mispredict_o, rob_flag_valid_o, rob_flag_o, rob_empty_o,
               perf_commit_cnt_o, perf_stall_cnt_o
    );
endinterface

// File: rtl/rob_commit.sv
// rob_commit: in-order reorder buffer and retirement unit.
//   clk_i   : clock
//   reset_i : asynchronous, active-high reset
//   bus     : rob_commit_if.slave
//             - dispatch : allocates an entry at the tail; dispatch_idx_o is the tail
//             - complete : per-FU done/flags/mispredict reports by ROB index
//             - commit   : registered register free/set, flag write and rollback strobes
// Retires at most one entry per cycle from the head. A mispredicted branch retires
// normally and flushes every younger entry.
// Optional feature: define ROB_COMMIT_PERF_EN to build the retire and head-stall
// counters; otherwise both perf outputs are tied to 0.
module rob_commit #(
    parameter int unsigned NUM_ROB      = 16,
    parameter int unsigned NUM_FU       = 4,
    parameter int unsigned NUM_PHYS_REG = 128,
    parameter int unsigned NUM_FLAGS    = 4
) (
    input logic         clk_i,
    input logic         reset_i,
    rob_commit_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_ROB);
    localparam int unsigned PR_W  = $clog2(NUM_PHYS_REG);
    localparam int unsigned CNT_W = IDX_W + 1;

    // Entry storage
    logic [NUM_ROB-1:0]   ent_valid_q, ent_valid_d;
    logic [NUM_ROB-1:0]   ent_done_q, ent_done_d;
    logic [NUM_ROB-1:0]   ent_has_dest_q, ent_has_dest_d;
    logic [NUM_ROB-1:0]   ent_mispred_q, ent_mispred_d;
    logic [PR_W-1:0]      ent_phys_new_q [NUM_ROB];
    logic [PR_W-1:0]      ent_phys_new_d [NUM_ROB];
    logic [PR_W-1:0]      ent_phys_old_q [NUM_ROB];
    logic [PR_W-1:0]      ent_phys_old_d [NUM_ROB];
    logic [NUM_FLAGS-1:0] ent_mask_q [NUM_ROB];
    logic [NUM_FLAGS-1:0] ent_mask_d [NUM_ROB];
    logic [NUM_FLAGS-1:0] ent_flags_q [NUM_ROB];
    logic [NUM_FLAGS-1:0] ent_flags_d [NUM_ROB];

    // Pointers and status
    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d, head_inc;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d, empty_q, empty_d;

    // Registered commit outputs
    logic                   phys_valid_q, phys_valid_d;
    logic [PR_W-1:0]        phys_cl_q, phys_cl_d;
    logic [PR_W-1:0]        phys_set_q, phys_set_d;
    logic                   mispred_out_q, mispred_out_d;
    logic                   flag_valid_q, flag_valid_d;
    logic [2*NUM_FLAGS-1:0] flag_out_q, flag_out_d;

    logic             retire, flush, dispatch_ok;
    logic [IDX_W-1:0] cidx;

    assign retire   = ent_valid_q[head_q] & ent_done_q[head_q];
    assign flush    = retire & ent_mispred_q[head_q];
    assign head_inc = head_q + IDX_W'(1);

    // A flushing retire kills any dispatch offered in the same cycle.
    assign bus.dispatch_ready_o = ready_q & ~flush;
    assign dispatch_ok          = bus.dispatch_valid_i & bus.dispatch_ready_o;
    assign bus.dispatch_idx_o   = tail_q;

    always_comb begin
        ent_valid_d    = ent_valid_q;
        ent_done_d     = ent_done_q;
        ent_has_dest_d = ent_has_dest_q;
        ent_mispred_d  = ent_mispred_q;
        ent_phys_new_d = ent_phys_new_q;
        ent_phys_old_d = ent_phys_old_q;
        ent_mask_d     = ent_mask_q;
        ent_flags_d    = ent_flags_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        cidx           = '0;

        if (flush) begin
            // Branch retires; everything younger disappears and the ROB restarts empty
            // just past it. Completions this cycle are dropped.
            ent_valid_d = '0;
            ent_done_d  = '0;
            head_d      = head_inc;
            tail_d      = head_inc;
            count_d     = '0;
        end else begin
            // Ascending loop order lets the highest FU index win on a shared target.
            for (int f = 0; f < NUM_FU; f++) begin
                if (bus.complete_valid_i[f]) begin
                    cidx = bus.complete_idx_i[f*IDX_W +: IDX_W];
                    if (ent_valid_q[cidx]) begin
                        ent_done_d[cidx]    = 1'b1;
                        ent_flags_d[cidx]   = bus.complete_flags_i[f*NUM_FLAGS +: NUM_FLAGS];
                        ent_mispred_d[cidx] = bus.complete_mispredict_i[f];
                    end
                end
            end
            if (retire) begin
                ent_valid_d[head_q] = 1'b0;
                ent_done_d[head_q]  = 1'b0;
                head_d              = head_inc;
            end
            if (dispatch_ok) begin
                ent_valid_d[tail_q]    = 1'b1;
                ent_done_d[tail_q]     = 1'b0;
                ent_mispred_d[tail_q]  = 1'b0;
                ent_has_dest_d[tail_q] = bus.dispatch_has_dest_i;
                ent_phys_new_d[tail_q] = bus.dispatch_phys_new_i;
                ent_phys_old_d[tail_q] = bus.dispatch_phys_old_i;
                ent_mask_d[tail_q]     = bus.dispatch_flag_mask_i;
                ent_flags_d[tail_q]    = '0;
                tail_d                 = tail_q + IDX_W'(1);
            end
            count_d = count_q + CNT_W'(dispatch_ok) - CNT_W'(retire);
        end

        ready_d = (count_d != CNT_W'(NUM_ROB));
        empty_d = (count_d == '0);

        phys_valid_d  = retire & ent_has_dest_q[head_q];
        phys_cl_d     = retire ? ent_phys_old_q[head_q] : '0;
        phys_set_d    = retire ? ent_phys_new_q[head_q] : '0;
        mispred_out_d = flush;
        flag_valid_d  = retire & (|ent_mask_q[head_q]);
        flag_out_d    = retire ? {ent_mask_q[head_q], ent_flags_q[head_q]} : '0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ent_valid_q    <= '0;
            ent_done_q     <= '0;
            ent_has_dest_q <= '0;
            ent_mispred_q  <= '0;
            for (int i = 0; i < NUM_ROB; i++) begin
                ent_phys_new_q[i] <= '0;
                ent_phys_old_q[i] <= '0;
                ent_mask_q[i]     <= '0;
                ent_flags_q[i]    <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            ready_q       <= 1'b1;
            empty_q       <= 1'b1;
            phys_valid_q  <= 1'b0;
            phys_cl_q     <= '0;
            phys_set_q    <= '0;
            mispred_out_q <= 1'b0;
            flag_valid_q  <= 1'b0;
            flag_out_q    <= '0;
        end else begin
            ent_valid_q    <= ent_valid_d;
            ent_done_q     <= ent_done_d;
            ent_has_dest_q <= ent_has_dest_d;
            ent_mispred_q  <= ent_mispred_d;
            ent_phys_new_q <= ent_phys_new_d;
            ent_phys_old_q <= ent_phys_old_d;
            ent_mask_q     <= ent_mask_d;
            ent_flags_q    <= ent_flags_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            ready_q        <= ready_d;
            empty_q        <= empty_d;
            phys_valid_q   <= phys_valid_d;
            phys_cl_q      <= phys_cl_d;
            phys_set_q     <= phys_set_d;
            mispred_out_q  <= mispred_out_d;
            flag_valid_q   <= flag_valid_d;
            flag_out_q     <= flag_out_d;
        end
    end

    assign bus.rob_phys_valid_o      = phys_valid_q;
    assign bus.rob_phys_reg_cl_o     = phys_cl_q;
    assign bus.rob_phys_reg_set_o    = phys_set_q;
    assign bus.rob_phys_mispredict_o = mispred_out_q;
    assign bus.rob_flag_valid_o      = flag_valid_q;
    assign bus.rob_flag_o            = flag_out_q;
    assign bus.rob_empty_o           = empty_q;

`ifdef ROB_COMMIT_PERF_EN
    logic [31:0] perf_commit_q, perf_stall_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            perf_commit_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (retire) begin
                perf_commit_q <= perf_commit_q + 32'd1;
            end
            if ((count_q != '0) && !ent_done_q[head_q]) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign bus.perf_commit_cnt_o = perf_commit_q;
    assign bus.perf_stall_cnt_o  = perf_stall_q;
`else
    assign bus.perf_commit_cnt_o = '0;
    assign bus.perf_stall_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed, self-checking bench for rob_commit with the default
// parameters (16 entries, 4 FUs, 128 physical registers, 4 flags).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_rob_commit;
    logic clk_i;
    logic reset_i;
    int   total;
    int   passed;

`ifdef ROB_COMMIT_PERF_EN
    localparam int unsigned EXP_COMMIT = 4;
    localparam int unsigned EXP_STALL  = 3;
`else
    localparam int unsigned EXP_COMMIT = 0;
    localparam int unsigned EXP_STALL  = 0;
`endif

    rob_commit_if #(
        .NUM_ROB(16), .NUM_FU(4), .NUM_PHYS_REG(128), .NUM_FLAGS(4)
    ) bus ();

    rob_commit #(
        .NUM_ROB(16), .NUM_FU(4), .NUM_PHYS_REG(128), .NUM_FLAGS(4)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_disp(input logic v, input logic hd, input logic [6:0] pn,
                            input logic [6:0] po, input logic [3:0] m);
        bus.dispatch_valid_i     = v;
        bus.dispatch_has_dest_i  = hd;
        bus.dispatch_phys_new_i  = pn;
        bus.dispatch_phys_old_i  = po;
        bus.dispatch_flag_mask_i = m;
    endtask

    task automatic set_comp(input logic [3:0] v, input logic [15:0] idx,
                            input logic [15:0] flg, input logic [3:0] mp);
        bus.complete_valid_i      = v;
        bus.complete_idx_i        = idx;
        bus.complete_flags_i      = flg;
        bus.complete_mispredict_i = mp;
    endtask

    task automatic do_reset();
        set_disp(1'b0, 1'b0, 7'd0, 7'd0, 4'd0);
        set_comp(4'd0, 16'd0, 16'd0, 4'd0);
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        tick();
    endtask

    initial begin
        total  = 0;
        passed = 0;
        do_reset();

        // Reset / idle state
        chk("rst_ready", 32'(bus.dispatch_ready_o), 1);
        chk("rst_empty", 32'(bus.rob_empty_o), 1);
        chk("rst_idx", 32'(bus.dispatch_idx_o), 0);
        chk("rst_pvalid", 32'(bus.rob_phys_valid_o), 0);
        chk("rst_fvalid", 32'(bus.rob_flag_valid_o), 0);
        chk("rst_mispred", 32'(bus.rob_phys_mispredict_o), 0);
        chk("rst_perf_c", bus.perf_commit_cnt_o, 0);
        chk("rst_perf_s", bus.perf_stall_cnt_o, 0);

        // Three dispatches, out-of-order completion, in-order retire
        set_disp(1'b1, 1'b1, 7'd10, 7'd1, 4'd0);
        tick();
        chk("d3_idx1", 32'(bus.dispatch_idx_o), 1);
        set_disp(1'b1, 1'b1, 7'd11, 7'd2, 4'd0);
        tick();
        set_disp(1'b1, 1'b1, 7'd12, 7'd3, 4'd0);
        tick();
        set_disp(1'b0, 1'b0, 7'd0, 7'd0, 4'd0);
        chk("d3_idx3", 32'(bus.dispatch_idx_o), 3);
        chk("d3_nempty", 32'(bus.rob_empty_o), 0);
        set_comp(4'b0001, 16'h0002, 16'h0000, 4'd0);
        tick();
        set_comp(4'b0001, 16'h0000, 16'h0000, 4'd0);
        tick();
        chk("d3_early_pv", 32'(bus.rob_phys_valid_o), 0);
        set_comp(4'b0001, 16'h0001, 16'h0000, 4'd0);
        tick();
        set_comp(4'd0, 16'd0, 16'd0, 4'd0);
        chk("d3_c0_pv", 32'(bus.rob_phys_valid_o), 1);
        chk("d3_c0_cl", 32'(bus.rob_phys_reg_cl_o), 1);
        chk("d3_c0_set", 32'(bus.rob_phys_reg_set_o), 10);
        tick();
        chk("d3_c1_pv", 32'(bus.rob_phys_valid_o), 1);
        chk("d3_c1_cl", 32'(bus.rob_phys_reg_cl_o), 2);
        chk("d3_c1_set", 32'(bus.rob_phys_reg_set_o), 11);
        tick();
        chk("d3_c2_cl", 32'(bus.rob_phys_reg_cl_o), 3);
        chk("d3_c2_set", 32'(bus.rob_phys_reg_set_o), 12);
        chk("d3_empty", 32'(bus.rob_empty_o), 1);
        tick();
        chk("d3_idle_pv", 32'(bus.rob_phys_valid_o), 0);

        // Fill all 16 entries; tail wraps 15 -> 0
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_disp(1'b1, 1'b1, 7'(20 + i), 7'(i), 4'd0);
            tick();
            if (i == 14) begin
                chk("fill_idx15", 32'(bus.dispatch_idx_o), 15);
                chk("fill_ready15", 32'(bus.dispatch_ready_o), 1);
            end
        end
        set_disp(1'b1, 1'b1, 7'd99, 7'd98, 4'd0);
        chk("full_ready", 32'(bus.dispatch_ready_o), 0);
        chk("full_idx_wrap", 32'(bus.dispatch_idx_o), 0);
        set_comp(4'b0001, 16'h0000, 16'h0000, 4'd0);
        tick();
        set_comp(4'd0, 16'd0, 16'd0, 4'd0);
        chk("full_ready_hold", 32'(bus.dispatch_ready_o), 0);
        tick();
        chk("full_ready_back", 32'(bus.dispatch_ready_o), 1);
        chk("full_c0_cl", 32'(bus.rob_phys_reg_cl_o), 0);
        chk("full_c0_set", 32'(bus.rob_phys_reg_set_o), 20);
        chk("full_idx_held", 32'(bus.dispatch_idx_o), 0);
        tick();
        set_disp(1'b0, 1'b0, 7'd0, 7'd0, 4'd0);
        chk("refill_idx", 32'(bus.dispatch_idx_o), 1);
        chk("refill_ready", 32'(bus.dispatch_ready_o), 0);

        // Reset with a full ROB
        reset_i = 1'b1;
        #2;
        chk("midrst_ready", 32'(bus.dispatch_ready_o), 1);
        chk("midrst_empty", 32'(bus.rob_empty_o), 1);
        chk("midrst_idx", 32'(bus.dispatch_idx_o), 0);
        tick();
        reset_i = 1'b0;
        tick();
        chk("midrst_pv", 32'(bus.rob_phys_valid_o), 0);

        // Flag write without a destination; FU3 and FU1 both hit idx0, FU3 wins
        set_disp(1'b1, 1'b0, 7'd5, 7'd6, 4'b0011);
        tick();
        set_disp(1'b0, 1'b0, 7'd0, 7'd0, 4'd0);
        set_comp(4'b1010, 16'h0000, 16'hA050, 4'd0);
        tick();
        set_comp(4'd0, 16'd0, 16'd0, 4'd0);
        tick();
        chk("flag_valid", 32'(bus.rob_flag_valid_o), 1);
        chk("flag_value", 32'(bus.rob_flag_o), 32'h3A);
        chk("flag_no_pv", 32'(bus.rob_phys_valid_o), 0);
        tick();
        chk("flag_valid_off", 32'(bus.rob_flag_valid_o), 0);

        // Mispredict on idx1 of 5 entries
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_disp(1'b1, 1'b1, 7'(40 + i), 7'(30 + i), 4'd0);
            tick();
        end
        set_disp(1'b0, 1'b0, 7'd0, 7'd0, 4'd0);
        chk("mp_idx5", 32'(bus.dispatch_idx_o), 5);
        set_comp(4'b0011, 16'h0010, 16'h0000, 4'b0010);
        tick();
        set_comp(4'd0, 16'd0, 16'd0, 4'd0);
        tick();
        chk("mp_c0_pv", 32'(bus.rob_phys_valid_o), 1);
        chk("mp_c0_set", 32'(bus.rob_phys_reg_set_o), 40);
        chk("mp_c0_mp", 32'(bus.rob_phys_mispredict_o), 0);
        chk("mp_flush_ready", 32'(bus.dispatch_ready_o), 0);
        set_disp(1'b1, 1'b1, 7'd77, 7'd76, 4'd0);
        set_comp(4'b0001, 16'h0002, 16'h0000, 4'd0);
        tick();
        set_disp(1'b0, 1'b0, 7'd0, 7'd0, 4'd0);
        set_comp(4'd0, 16'd0, 16'd0, 4'd0);
        chk("mp_c1_pv", 32'(bus.rob_phys_valid_o), 1);
        chk("mp_c1_cl", 32'(bus.rob_phys_reg_cl_o), 31);
        chk("mp_c1_set", 32'(bus.rob_phys_reg_set_o), 41);
        chk("mp_c1_mp", 32'(bus.rob_phys_mispredict_o), 1);
        chk("mp_tail", 32'(bus.dispatch_idx_o), 2);
        tick();
        chk("mp_empty", 32'(bus.rob_empty_o), 1);
        chk("mp_mp_off", 32'(bus.rob_phys_mispredict_o), 0);
        chk("mp_ready", 32'(bus.dispatch_ready_o), 1);
        set_comp(4'b0111, 16'h0432, 16'h0000, 4'd0);
        tick();
        set_comp(4'd0, 16'd0, 16'd0, 4'd0);
        tick();
        tick();
        chk("mp_late_pv", 32'(bus.rob_phys_valid_o), 0);
        chk("mp_late_empty", 32'(bus.rob_empty_o), 1);

        // Performance counters: 4 retires, 3 head-stall cycles
        do_reset();
        set_disp(1'b1, 1'b1, 7'd50, 7'd51, 4'd0);
        tick();
        set_disp(1'b1, 1'b1, 7'd52, 7'd53, 4'd0);
        tick();
        set_disp(1'b1, 1'b1, 7'd54, 7'd55, 4'd0);
        tick();
        set_disp(1'b1, 1'b1, 7'd56, 7'd57, 4'd0);
        set_comp(4'b0111, 16'h0210, 16'h0000, 4'd0);
        tick();
        set_disp(1'b0, 1'b0, 7'd0, 7'd0, 4'd0);
        set_comp(4'b0001, 16'h0003, 16'h0000, 4'd0);
        tick();
        set_comp(4'd0, 16'd0, 16'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        chk("perf_empty", 32'(bus.rob_empty_o), 1);
        chk("perf_commit", bus.perf_commit_cnt_o, EXP_COMMIT);
        chk("perf_stall", bus.perf_stall_cnt_o, EXP_STALL);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
